lexer: RTL and testbench

//  Character-to-token front end feeding the LR parser. Consumes an ASCII

---
 rtl/lexer_if.sv | 52 +++++
 rtl/lexer.sv | 218 +++++++++++++++++++++
 tb/tb_lexer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lexer_if.sv
// ---------------------------------------------------------------------------
// lexer_if
//   Groups the character-input handshake and the token-output handshake of
//   the lexer into one bundle. CLK and RST are not part of it; they stay as
//   plain ports on the lexer.
//
//   Signals
//     I_VALID  character on I_CHAR is valid (transfers when I_VALID && O_READY)
//     I_CHAR   8-bit ASCII character
//     O_READY  lexer accepts a character this cycle
//     RECEIVE  parser pulse: current token consumed
//     O_VALID  O_TOKEN valid, held until consumed
//     O_TOKEN  {kind[15:8], value[7:0]}
//     O_DONE   EOF token consumed, sticky until reset
//     O_ERROR  illegal character seen, sticky until reset
//
//   Modports
//     slave    the lexer itself
//     master   whatever feeds characters and consumes tokens
// ---------------------------------------------------------------------------
interface lexer_if;
  logic        I_VALID;
  logic [7:0]  I_CHAR;
  logic        O_READY;
  logic        RECEIVE;
  logic        O_VALID;
  logic [15:0] O_TOKEN;
  logic        O_DONE;
  logic        O_ERROR;

  modport slave (
    input  I_VALID,
    input  I_CHAR,
    input  RECEIVE,
    output O_READY,
    output O_VALID,
    output O_TOKEN,
    output O_DONE,
    output O_ERROR
  );

  modport master (
    output I_VALID,
    output I_CHAR,
    output RECEIVE,
    input  O_READY,
    input  O_VALID,
    input  O_TOKEN,
    input  O_DONE,
    input  O_ERROR
  );
endinterface

// File: rtl/lexer.sv
// ---------------------------------------------------------------------------
// lexer
//   Character-to-token front end for the LR parser. Turns an ASCII stream of
//   unsigned decimal integers, '+', '*', blanks/tabs and an end character
//   into 16-bit tokens {kind, value}. Each token is held on the output until
//   the parser pulses RECEIVE.
//
//   Ports
//     CLK   clock, rising edge
//     RST   synchronous reset, active-low
//     bus   lexer_if.slave: I_VALID/I_CHAR/O_READY character handshake,
//           O_VALID/O_TOKEN/RECEIVE token handshake, O_DONE, O_ERROR
//
//   Parameters
//     EOF_CHAR  end-of-input character (default line feed)
//     K_NUM, K_ADD, K_MUL, K_EOF  token kinds
//
//   Build option
//     LEXER_NUM_SAT_EN  when defined, a number that grows past 255 clamps to
//                       8'hFF; otherwise it wraps modulo 256.
// ---------------------------------------------------------------------------
module lexer #(
  parameter logic [7:0] EOF_CHAR = 8'h0A,
  parameter logic [7:0] K_NUM    = 8'h00,
  parameter logic [7:0] K_ADD    = 8'h01,
  parameter logic [7:0] K_MUL    = 8'h02,
  parameter logic [7:0] K_EOF    = 8'h03
) (
  input  logic   CLK,
  input  logic   RST,
  lexer_if.slave bus
);

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

  typedef enum logic [2:0] {
    L_SCAN,
    L_NUM,
    L_DRAIN,
    L_DONE,
    L_ERROR
  } lex_state_t;

  lex_state_t  state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] pend_token_q, pend_token_d;
  logic        valid_q, valid_d;
  logic [15:0] token_q, token_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        ready;
  logic        accept;
  logic        consume;
  logic [7:0]  ch;
  logic        is_digit;
  logic        is_ws;
  logic        is_op;
  logic        is_eof;
  logic [7:0]  digit;
  logic [15:0] op_token;
  logic [7:0]  acc_next;

  // Character classification and the two handshake qualifiers.
  always_comb begin
    ch       = bus.I_CHAR;
    is_digit = (ch >= CH_ZERO) && (ch <= CH_NINE);
    is_ws    = (ch == CH_SPACE) || (ch == CH_TAB);
    is_op    = (ch == CH_PLUS) || (ch == CH_STAR);
    is_eof   = (ch == EOF_CHAR);
    digit    = ch - CH_ZERO;
    op_token = {(ch == CH_PLUS) ? K_ADD : K_MUL, 8'h00};
    ready    = ((state_q == L_SCAN) || (state_q == L_NUM)) && !pend_valid_q && !valid_q;
    accept   = bus.I_VALID && ready;
    consume  = bus.RECEIVE && valid_q;
  end

`ifdef LEXER_NUM_SAT_EN
  logic [11:0] acc_x8;
  logic [11:0] acc_x2;
  logic [11:0] prod;

  // acc*10 + digit built from two shifts at 12 bits; anything past 255 clamps,
  // and once clamped every further digit keeps it at 8'hFF.
  always_comb begin
    acc_x8   = {1'b0, acc_q, 3'b000};
    acc_x2   = {3'b000, acc_q, 1'b0};
    prod     = acc_x8 + acc_x2 + {4'b0000, digit};
    acc_next = (prod > 12'd255) ? 8'hFF : prod[7:0];
  end
`else
  // Wrapping build: only the low 8 bits of acc*10 + digit survive, so the sum
  // is formed directly at 8 bits (same result as truncating the 12-bit sum).
  always_comb begin
    acc_next = {acc_q[4:0], 3'b000} + {acc_q[6:0], 1'b0} + digit;
  end
`endif

  // Next-state logic. Order matters: a consume frees the output register, a
  // pending token then refills it on the same edge, and only after that is a
  // newly accepted character considered (accept implies nothing is held).
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    pend_valid_d = pend_valid_q;
    pend_token_d = pend_token_q;
    valid_d      = valid_q;
    token_d      = token_q;
    done_d       = done_q;
    error_d      = error_q;

    if (consume) begin
      valid_d = 1'b0;
      if (state_q == L_DRAIN) begin
        done_d  = 1'b1;
        state_d = L_DONE;
      end
    end

    if (pend_valid_q && (consume || !valid_q)) begin
      token_d      = pend_token_q;
      valid_d      = 1'b1;
      pend_valid_d = 1'b0;
      if (pend_token_q[15:8] == K_EOF) begin
        state_d = L_DRAIN;
      end
    end

    if (accept) begin
      case (state_q)
        L_SCAN: begin
          if (is_ws) begin
            state_d = L_SCAN;
          end else if (is_digit) begin
            acc_d   = digit;
            state_d = L_NUM;
          end else if (is_op) begin
            token_d = op_token;
            valid_d = 1'b1;
          end else if (is_eof) begin
            token_d = {K_EOF, 8'h00};
            valid_d = 1'b1;
            state_d = L_DRAIN;
          end else begin
            error_d = 1'b1;
            state_d = L_ERROR;
          end
        end
        L_NUM: begin
          if (is_digit) begin
            acc_d = acc_next;
          end else if (is_ws) begin
            token_d = {K_NUM, acc_q};
            valid_d = 1'b1;
            state_d = L_SCAN;
          end else if (is_op || is_eof) begin
            // The number goes out now; the terminating op/EOF waits behind it.
            token_d      = {K_NUM, acc_q};
            valid_d      = 1'b1;
            pend_token_d = is_op ? op_token : {K_EOF, 8'h00};
            pend_valid_d = 1'b1;
            state_d      = L_SCAN;
          end else begin
            error_d = 1'b1;
            state_d = L_ERROR;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // The error state is absorbing: nothing is offered and nothing waits.
    if (state_q == L_ERROR) begin
      error_d      = 1'b1;
      valid_d      = 1'b0;
      pend_valid_d = 1'b0;
      state_d      = L_ERROR;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= L_SCAN;
      acc_q        <= 8'h00;
      pend_valid_q <= 1'b0;
      pend_token_q <= 16'h0000;
      valid_q      <= 1'b0;
      token_q      <= 16'h0000;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      pend_valid_q <= pend_valid_d;
      pend_token_q <= pend_token_d;
      valid_q      <= valid_d;
      token_q      <= token_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.O_READY = ready;
  assign bus.O_VALID = valid_q;
  assign bus.O_TOKEN = token_q;
  assign bus.O_DONE  = done_q;
  assign bus.O_ERROR = error_q;

endmodule

// File: tb/tb_lexer.sv
// ---------------------------------------------------------------------------
// tb_lexer
//   Self-checking bench for lexer. A table of character strings with their
//   expected token sequences is streamed through the block; expected tokens
//   sit in a scoreboard queue and are compared as the parser side consumes
//   them. Hand-written sequences cover latency, errors, reset mid-number and
//   the done state. Honours LEXER_NUM_SAT_EN for the overflow expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lexer;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  lexer_if bus();

  lexer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

`ifdef LEXER_NUM_SAT_EN
  localparam logic [15:0] NUM300 = 16'h00FF;
  localparam logic [15:0] NUM256 = 16'h00FF;
  localparam logic [15:0] NUM999 = 16'h00FF;
`else
  localparam logic [15:0] NUM300 = 16'h002C;
  localparam logic [15:0] NUM256 = 16'h0000;
  localparam logic [15:0] NUM999 = 16'h00E7;
`endif

  typedef struct packed {
    logic [95:0] exp;
    logic [3:0]  nexp;
    logic [3:0]  rdelay;
  } vec_t;

  localparam int NVEC = 6;

  vec_t        vecs [NVEC];
  string       texts [NVEC];
  logic [15:0] sb_q [$];
  int          checks = 0;
  int          errors = 0;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string what, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", what, actual, expected);
    end
  endtask

  // Synchronous reset for one edge, outputs checked while reset is still low.
  task automatic applyReset();
    @(negedge CLK);
    RST         = 1'b0;
    bus.I_VALID = 1'b0;
    bus.RECEIVE = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset O_VALID", 16'(bus.O_VALID), 16'd0);
    checkOutput("reset O_TOKEN", bus.O_TOKEN, 16'h0000);
    checkOutput("reset O_DONE", 16'(bus.O_DONE), 16'd0);
    checkOutput("reset O_ERROR", 16'(bus.O_ERROR), 16'd0);
    RST = 1'b1;
  endtask

  // Offer one character (entered at a negedge) until it transfers.
  task automatic sendChar(input logic [7:0] c);
    bit taken;
    taken       = 1'b0;
    bus.I_CHAR  = c;
    bus.I_VALID = 1'b1;
    for (int t = 0; t < 400 && !taken; t++) begin
      taken = bus.O_READY;
      @(posedge CLK);
      @(negedge CLK);
    end
    bus.I_VALID = 1'b0;
    checkOutput("char accepted", 16'(taken), 16'd1);
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) begin
      sendChar(s[i]);
    end
  endtask

  // Parser side: waits rdelay cycles after each O_VALID, checks the token was
  // held steady, then pulses RECEIVE and compares against the scoreboard.
  task automatic consumeTokens(input int rdelay);
    int budget;
    budget = 3000;
    while (sb_q.size() > 0 && budget > 0) begin
      if (bus.O_VALID === 1'b1) begin
        logic [15:0] exp;
        bit steady;
        exp    = sb_q.pop_front();
        steady = 1'b1;
        for (int d = 0; d < rdelay; d++) begin
          if (bus.O_TOKEN !== exp || bus.O_READY !== 1'b0 || bus.O_VALID !== 1'b1) steady = 1'b0;
          @(negedge CLK);
        end
        checkOutput("token", bus.O_TOKEN, exp);
        checkOutput("token held", 16'(steady), 16'd1);
        bus.RECEIVE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.RECEIVE = 1'b0;
      end else begin
        @(negedge CLK);
        budget--;
      end
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL token timeout: got %0d tokens outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Hold a character valid for n cycles; the block must stay closed.
  task automatic holdIgnored(input string what, input logic [7:0] c, input int n);
    bit quiet;
    quiet       = 1'b1;
    bus.I_CHAR  = c;
    bus.I_VALID = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.O_READY !== 1'b0 || bus.O_VALID !== 1'b0) quiet = 1'b0;
    end
    bus.I_VALID = 1'b0;
    checkOutput(what, 16'(quiet), 16'd1);
  endtask

  task automatic runVector(input int k, input bit do_reset);
    if (do_reset) applyReset();
    for (int j = 0; j < int'(vecs[k].nexp); j++) begin
      sb_q.push_back(vecs[k].exp[95 - 16*j -: 16]);
    end
    fork
      applyStimulus(texts[k]);
      consumeTokens(int'(vecs[k].rdelay));
    join
    checkOutput("O_DONE after EOF", 16'(bus.O_DONE), 16'd1);
    checkOutput("O_READY after EOF", 16'(bus.O_READY), 16'd0);
  endtask

  // Global guard so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST         = 1'b0;
    bus.I_VALID = 1'b0;
    bus.I_CHAR  = 8'h00;
    bus.RECEIVE = 1'b0;

    texts[0] = "12+3*4\n";
    vecs[0]  = '{exp: {16'h000C, 16'h0100, 16'h0003, 16'h0200, 16'h0004, 16'h0300}, nexp: 4'd6, rdelay: 4'd2};
    texts[1] = "7+1\n";
    vecs[1]  = '{exp: {16'h0007, 16'h0100, 16'h0001, 16'h0300, 16'h0000, 16'h0000}, nexp: 4'd4, rdelay: 4'd10};
    texts[2] = "300\n";
    vecs[2]  = '{exp: {NUM300, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, nexp: 4'd2, rdelay: 4'd1};
    texts[3] = "0 255 256+9\n";
    vecs[3]  = '{exp: {16'h0000, 16'h00FF, NUM256, 16'h0100, 16'h0009, 16'h0300}, nexp: 4'd6, rdelay: 4'd0};
    texts[4] = "  42\t*\t8\n";
    vecs[4]  = '{exp: {16'h002A, 16'h0200, 16'h0008, 16'h0300, 16'h0000, 16'h0000}, nexp: 4'd4, rdelay: 4'd3};
    texts[5] = "999\n";
    vecs[5]  = '{exp: {NUM999, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, nexp: 4'd2, rdelay: 4'd0};

    repeat (2) @(negedge CLK);

    // Reset state and first-token latency, pending token on the consume edge.
    applyReset();
    checkOutput("O_READY after reset", 16'(bus.O_READY), 16'd1);
    sendChar("7");
    checkOutput("no token mid-number", 16'(bus.O_VALID), 16'd0);
    sendChar("+");
    checkOutput("latency O_VALID", 16'(bus.O_VALID), 16'd1);
    checkOutput("latency O_TOKEN", bus.O_TOKEN, 16'h0007);
    checkOutput("O_READY while holding", 16'(bus.O_READY), 16'd0);
    bus.RECEIVE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.RECEIVE = 1'b0;
    checkOutput("pending O_VALID", 16'(bus.O_VALID), 16'd1);
    checkOutput("pending O_TOKEN", bus.O_TOKEN, 16'h0100);
    bus.RECEIVE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.RECEIVE = 1'b0;
    checkOutput("drained O_VALID", 16'(bus.O_VALID), 16'd0);
    checkOutput("drained O_READY", 16'(bus.O_READY), 16'd1);

    // Table-driven streams; after the first one, the done state is probed.
    runVector(0, 1'b1);
    holdIgnored("done ignores '1'", "1", 6);
    holdIgnored("done ignores '+'", "+", 6);
    bus.RECEIVE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.RECEIVE = 1'b0;
    checkOutput("done sticky", 16'(bus.O_DONE), 16'd1);
    checkOutput("done no token", 16'(bus.O_VALID), 16'd0);
    for (int k = 1; k < NVEC; k++) begin
      runVector(k, 1'b1);
    end

    // Illegal character after a number; later input is ignored.
    applyReset();
    sb_q.push_back(16'h0005);
    fork
      applyStimulus(" \t5 ");
      consumeTokens(1);
    join
    sendChar("a");
    checkOutput("error O_ERROR", 16'(bus.O_ERROR), 16'd1);
    checkOutput("error O_VALID", 16'(bus.O_VALID), 16'd0);
    checkOutput("error O_READY", 16'(bus.O_READY), 16'd0);
    holdIgnored("error ignores input", "b", 5);
    checkOutput("error sticky", 16'(bus.O_ERROR), 16'd1);

    // Reset in the middle of a number, then a fresh stream.
    applyReset();
    sendChar("4");
    applyReset();
    sb_q.push_back(16'h0009);
    sb_q.push_back(16'h0300);
    fork
      applyStimulus("9\n");
      consumeTokens(1);
    join
    checkOutput("O_DONE after restart", 16'(bus.O_DONE), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
